// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    // {CPOL, CPHA}; only mode 0 is implemented.
    localparam logic [1:0] SPI_MODE = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: paces every phase and
// produces a registered sclk plus one-cycle rise/fall strobes.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic run,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] TOP = CW'(HALF - 1);
    localparam logic IDLE_LVL = SPI_MODE[1];

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TOP);
    assign rise = tick && run && (sclk == IDLE_LVL);
    assign fall = tick && run && (sclk != IDLE_LVL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            sclk <= IDLE_LVL;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= IDLE_LVL;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && run) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: phase FSM, half-period edge counter and the
// tx/rx shift registers; every pin is driven straight from a flop.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SPI_DATA_W-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int HALF = CLK_DIV / 2;
    localparam logic [3:0] LAST_TICK = 4'd15;
    localparam logic [3:0] LAST_FALL = 4'd14;

    spi_state_e state, state_n;
    logic [3:0] edge_cnt;
    logic [SPI_DATA_W-1:0] tx_sh;
    logic [SPI_DATA_W-1:0] rx_sh;
    logic en, run, tick, rise, fall;
    logic accept, finish;

    assign en = (state != IDLE);

    spi_clk_gen #(
        .HALF(HALF)
    ) u_clk_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .run (run),
        .sclk(sclk),
        .tick(tick),
        .rise(rise),
        .fall(fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The final XFER half-period is the low phase after the 8th fall,
    // so sclk must not toggle on that tick.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        run     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: begin
                run = 1'b1;
                if (tick) state_n = XFER;
            end
            XFER: begin
                run = (edge_cnt != LAST_TICK);
                if (tick && edge_cnt == LAST_TICK) state_n = HOLD;
            end
            HOLD: begin
                if (tick) begin
                    state_n = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (state != XFER) begin
            edge_cnt <= '0;
        end else if (tick) begin
            edge_cnt <= edge_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            mosi    <= 1'b0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                cs    <= 1'b0;
                busy  <= 1'b1;
                tx_sh <= tx_data;
                rx_sh <= '0;
                mosi  <= (LSB_FIRST != 0) ? tx_data[0]
                                          : tx_data[SPI_DATA_W-1];
            end else if (finish) begin
                cs      <= 1'b1;
                busy    <= 1'b0;
                mosi    <= 1'b0;
                rx_data <= rx_sh;
            end else begin
                if (fall && edge_cnt != LAST_FALL) begin
                    if (LSB_FIRST != 0) begin
                        tx_sh <= tx_sh >> 1;
                        mosi  <= tx_sh[1];
                    end else begin
                        tx_sh <= tx_sh << 1;
                        mosi  <= tx_sh[SPI_DATA_W-2];
                    end
                end
                if (rise) begin
                    rx_sh <= (LSB_FIRST != 0)
                           ? {miso, rx_sh[SPI_DATA_W-1:1]}
                           : {rx_sh[SPI_DATA_W-2:0], miso};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: timing model checked every cycle on two
// configurations, plus directed transfers with literal results.
module tb_spi_master;

    localparam int DIV0 = 4;
    localparam int LSB0 = 1;
    localparam int DIV1 = 2;
    localparam int LSB1 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] busy, done, sclk, cs, mosi, miso;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    logic lb0 = 1'b1;
    logic [7:0] slv = 8'hAD;
    logic [2:0] sidx = 3'd0;
    logic [7:0] seq = 8'h00;
    logic p_cs = 1'b1;
    logic p_sclk = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign miso = {mosi[1], lb0 ? mosi[0] : slv[sidx]};

    spi_master #(.CLK_DIV(DIV0), .LSB_FIRST(LSB0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]),
        .busy(busy[0]), .done(done[0]), .rx_data(rx_data[0]),
        .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    spi_master #(.CLK_DIV(DIV1), .LSB_FIRST(LSB1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]),
        .busy(busy[1]), .done(done[1]), .rx_data(rx_data[1]),
        .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    task automatic chkb(input string nm, input int d, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, d, a, e);
        end
    endtask

    task automatic chkv(input string nm, input int d, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, d, a, e);
        end
    endtask

    task automatic chki(input string nm, input int d, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, d, a, e);
        end
    endtask

    function automatic int hh(input int d);
        return (d == 0) ? DIV0 / 2 : DIV1 / 2;
    endfunction

    function automatic bit lsbf(input int d);
        return (d == 0) ? (LSB0 != 0) : (LSB1 != 0);
    endfunction

    // LSB-first mode-0 slave on instance 0: drives on cs fall and
    // sclk falls, records mosi on sclk rises.
    always @(sclk[0] or cs[0]) begin
        if (!cs[0] && p_cs) begin
            sidx = 3'd0;
            seq  = 8'h00;
        end else if (!cs[0] && sclk[0] && !p_sclk) begin
            seq = {seq[6:0], mosi[0]};
        end else if (!cs[0] && !sclk[0] && p_sclk) begin
            sidx = sidx + 3'd1;
        end
        p_cs   = cs[0];
        p_sclk = sclk[0];
    end

    // Model: mk = cycles since the accepting edge (-1 idle,
    // 18*H is the done cycle).
    int mk [2] = '{-1, -1};
    logic [7:0] m_tx [2] = '{8'h00, 8'h00};
    logic [7:0] m_rx [2] = '{8'h00, 8'h00};
    logic [7:0] m_rxs [2] = '{8'h00, 8'h00};
    int m_h, m_nk, m_i;

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            m_h = hh(d);
            if (!rst) begin
                mk[d]    = -1;
                m_tx[d]  = 8'h00;
                m_rx[d]  = 8'h00;
                m_rxs[d] = 8'h00;
            end else if (mk[d] >= 0 && mk[d] < 18 * m_h) begin
                m_nk = mk[d] + 1;
                if (m_nk >= m_h && m_nk < 17 * m_h && (m_nk - m_h) % (2 * m_h) == 0) begin
                    m_i = (m_nk - m_h) / (2 * m_h);
                    m_rxs[d][lsbf(d) ? m_i : 7 - m_i] = miso[d];
                end
                if (m_nk == 18 * m_h) m_rx[d] = m_rxs[d];
                mk[d] = m_nk;
            end else if (start[d]) begin
                mk[d]    = 0;
                m_tx[d]  = tx_data[d];
                m_rxs[d] = 8'h00;
            end else begin
                mk[d] = -1;
            end
        end
    end

    int c_h, c_k, c_bi;
    logic c_act, c_sclk, c_mosi;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            c_h   = hh(d);
            c_k   = mk[d];
            c_act = (c_k >= 0 && c_k < 18 * c_h);
            c_sclk = c_act && c_k >= c_h && c_k < 17 * c_h
                     && ((c_k - c_h) / c_h) % 2 == 0;
            c_bi = c_act ? c_k / (2 * c_h) : 0;
            if (c_bi > 7) c_bi = 7;
            c_mosi = c_act ? m_tx[d][lsbf(d) ? c_bi : 7 - c_bi] : 1'b0;
            chkb("cs", d, cs[d], !c_act);
            chkb("busy", d, busy[d], c_act);
            chkb("done", d, done[d], c_k == 18 * c_h);
            chkb("sclk", d, sclk[d], c_sclk);
            chkb("mosi", d, mosi[d], c_mosi);
            chkv("rx_data", d, rx_data[d], m_rx[d]);
        end
    end

    int lo [2] = '{0, 0};
    int hi [2] = '{0, 0};
    int last_lo [2] = '{0, 0};
    int last_hi [2] = '{0, 0};
    int ndone [2] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!cs[d]) begin
                lo[d]++;
                if (hi[d] > 0) last_hi[d] = hi[d];
                hi[d] = 0;
            end else begin
                hi[d]++;
                if (lo[d] > 0) last_lo[d] = lo[d];
                lo[d] = 0;
            end
            if (done[d]) ndone[d]++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input bit tog, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (tog) tx_data[d] = ~tx_data[d];
        end while (!done[d] && n < 400);
        chkb("done_seen", d, done[d], 1'b1);
    endtask

    task automatic xfer(input int d, input logic [7:0] b, output int n, output logic fm);
        tx_data[d] = b;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        fm = mosi[d];
        n = 1;
        while (!done[d] && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chkb("done_seen", d, done[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nd;
        logic fm;
        logic [7:0] cap2;
        logic [7:0] vec [4];
        vec = '{8'h00, 8'hFF, 8'h80, 8'h3C};
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        #1 rst = 1'b0;
        repeat (3) sync();
        chkb("rst_cs", 0, cs[0], 1'b1);
        chkb("rst_sclk", 0, sclk[0], 1'b0);
        chkb("rst_busy", 0, busy[0], 1'b0);
        chkb("rst_mosi", 0, mosi[0], 1'b0);
        chkv("rst_rx", 0, rx_data[0], 8'h00);

        rst = 1'b1;
        xfer(0, 8'hA5, n, fm);
        chki("latency", 0, n, 37);
        chkv("loop_rx", 0, rx_data[0], 8'hA5);
        chkb("first_mosi", 0, fm, 1'b1);
        @(negedge clk);
        #1;
        chki("cs_low_len", 0, last_lo[0], 36);

        for (int v = 0; v < 4; v++) begin
            sync();
            xfer(0, vec[v], n, fm);
            chkv("vec_rx", 0, rx_data[0], vec[v]);
        end

        sync();
        lb0 = 1'b0;
        xfer(0, 8'hA5, n, fm);
        chkv("slave_rx", 0, rx_data[0], 8'hAD);
        chkv("mosi_seq", 0, seq, 8'b1010_0101);
        lb0 = 1'b1;

        sync();
        tx_data[0] = 8'h5A;
        start[0] = 1'b1;
        wait_done(0, 1'b1, n);
        chki("held_latency", 0, n, 37);
        chkv("held_rx", 0, rx_data[0], 8'h5A);
        cap2 = tx_data[0];
        sync();
        start[0] = 1'b0;
        chkb("restart_cs", 0, cs[0], 1'b0);
        @(negedge clk);
        #1;
        chki("cs_high_len", 0, last_hi[0], 1);
        sync();
        wait_done(0, 1'b0, n);
        chkv("second_rx", 0, rx_data[0], cap2);

        sync();
        tx_data[0] = 8'hC3;
        start[0] = 1'b1;
        sync();
        start[0] = 1'b0;
        repeat (10) sync();
        chkb("sclk_pre_rst", 0, sclk[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        chkb("abort_cs", 0, cs[0], 1'b1);
        chkb("abort_sclk", 0, sclk[0], 1'b0);
        chkb("abort_busy", 0, busy[0], 1'b0);
        nd = ndone[0];
        repeat (2) sync();
        rst = 1'b1;
        repeat (60) sync();
        chki("abort_no_done", 0, ndone[0], nd);
        chkv("abort_rx", 0, rx_data[0], 8'h00);

        xfer(1, 8'h3C, n, fm);
        chki("latency", 1, n, 19);
        chkv("loop_rx", 1, rx_data[1], 8'h3C);
        chkb("first_mosi", 1, fm, 1'b0);
        @(negedge clk);
        #1;
        chki("cs_low_len", 1, last_lo[1], 18);
        sync();
        xfer(1, 8'h96, n, fm);
        chkv("loop_rx2", 1, rx_data[1], 8'h96);
        chkb("first_mosi2", 1, fm, 1'b1);

        repeat (5) sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per sclk period; even, >= 2; HALF = CLK_DIV/2.
REQ-002 Parameter LSB_FIRST, default 1: 1 = bit 0 shifted first on both mosi and miso; 0 = bit 7 first.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 tx_data  input  8  byte to transmit; captured on the accepted start cycle.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse at transfer end.
REQ-009 rx_data  output  8  last received byte; updated only with done.
REQ-010 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 cs  output  1  chip select, active-low.
REQ-012 mosi  output  1  serial data to device.
REQ-013 miso  input  1  serial data from device.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, XFER, HOLD.
REQ-015 IDLE: cs=1, sclk=0, busy=0; start=1 latches tx_data into tx shift register, moves to SETUP; cs=0 and busy=1 from the next cycle.
REQ-016 SETUP: lasts HALF cycles, sclk=0, mosi presents first bit.
REQ-017 XFER: sclk toggles every HALF cycles, 16 half-periods (8 rising, 8 falling edges).
REQ-018 Each sclk rising edge samples miso into rx shift register.
REQ-019 Each sclk falling edge except the 8th shifts tx register; mosi presents next bit.
REQ-020 HOLD: after 8th falling edge, sclk=0, lasts HALF cycles; then cs=1, busy=0, done=1, rx_data loaded, state IDLE, all in the same cycle.
REQ-021 cs SHALL stay low for exactly 18*HALF cycles per transfer (36 at default).
REQ-022 start while busy SHALL be ignored; tx_data changes while busy SHALL not affect the transfer.
REQ-023 start on the done cycle SHALL be accepted; cs then stays high for exactly 1 cycle.
REQ-024 Bit/edge counter SHALL be 4 bits and SHALL saturate-free wrap only via FSM reset to 0 in IDLE.
REQ-025 mosi SHALL be 0 while cs=1.
REQ-026 sclk, cs, mosi, busy, done SHALL be driven directly from flops (glitch-free).

Reset
REQ-027 rst low SHALL immediately force: state IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00, shift registers and counters 0.
REQ-028 Reset mid-transfer SHALL abort with no done pulse and no rx_data update.
REQ-029 First start SHALL be accepted on the first clk rising edge after rst deasserts.

Structure
REQ-030 Shared package spi_pkg SHALL hold SPI_DATA_W=8, the state enum (IDLE, SETUP, XFER, HOLD) and the mode constant.
REQ-031 Sub-module spi_clk_gen SHALL hold the HALF-period counter, output sclk and one-cycle rise/fall strobes, enabled by the FSM.
REQ-032 spi_master SHALL hold the FSM, edge counter, and tx/rx shift registers.

Verification
REQ-033 Loopback mosi->miso, tx_data=8'hA5, start pulse -> done after 1+36 cycles, rx_data=8'hA5, cs low exactly 36 cycles.
REQ-034 miso driven by an LSB-first mode-0 slave model preloaded 8'hAD -> rx_data=8'hAD, mosi bit sequence 1,0,1,0,0,1,0,1 for tx 8'hA5.
REQ-035 start held high for entire transfer with tx_data toggling -> exactly one transfer of originally captured byte, then second transfer starts on done cycle with cs high 1 cycle.
REQ-036 rst asserted at cycle 10 of a transfer -> cs=1, sclk=0 same cycle, no done, rx_data stays 8'h00.
REQ-037 CLK_DIV=2, LSB_FIRST=0, loopback tx 8'h3C -> cs low 18 cycles, rx_data=8'h3C, first mosi bit 0 (MSB).
